// File: rtl/mandel_pkg.sv
// Shared definitions for the mandelbrot configuration loader: frame width
// helper, default field layout and FSM state encoding.
package mandel_pkg;

  localparam int DEF_BITWIDTH   = 11;
  localparam int DEF_CTRWIDTH   = 7;
  localparam int DEF_SCALEWIDTH = 2;

  function automatic int cfg_width(input int scalewidth, input int bitwidth,
                                   input int ctrwidth);
    return scalewidth + 2 * bitwidth + ctrwidth;
  endfunction

  // Field LSB positions inside the staging word for the default widths.
  localparam int DEF_CFG_WIDTH = cfg_width(DEF_SCALEWIDTH, DEF_BITWIDTH, DEF_CTRWIDTH);
  localparam int DEF_CTR_LSB   = 0;
  localparam int DEF_CR_LSB    = DEF_CTRWIDTH;
  localparam int DEF_CI_LSB    = DEF_CTRWIDTH + DEF_BITWIDTH;
  localparam int DEF_SCALE_LSB = DEF_CTRWIDTH + 2 * DEF_BITWIDTH;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

endpackage

// File: rtl/mandel_cfg_loader.sv
// Framed bit-serial configuration loader: length-checked staging, atomic
// commit while the core is idle, and a daisy-chain serial output.
module mandel_cfg_loader
  import mandel_pkg::*;
#(
  parameter int BITWIDTH   = 11,
  parameter int CTRWIDTH   = 7,
  parameter int SCALEWIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sin_frame,
  input  logic                  sin_valid,
  input  logic                  sin_data,
  input  logic                  core_busy,
  output logic                  sout_data,
  output logic [SCALEWIDTH-1:0] scaling,
  output logic [BITWIDTH-1:0]   ci_offset,
  output logic [BITWIDTH-1:0]   cr_offset,
  output logic [CTRWIDTH-1:0]   max_ctr,
  output logic                  cfg_update,
  output logic                  cfg_pending,
  output logic                  cfg_error,
  output logic                  cfg_valid
);

  localparam int CFG_WIDTH = cfg_width(SCALEWIDTH, BITWIDTH, CTRWIDTH);
  localparam int CNTW      = $clog2(CFG_WIDTH + 2);
  localparam int CI_LSB    = CTRWIDTH + BITWIDTH;
  localparam int CR_LSB    = CTRWIDTH;

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(CFG_WIDTH);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(CFG_WIDTH + 1);

  // Handshake: a bit is taken on every clock where sin_frame and sin_valid
  // are both high; there is no backpressure, the loader is always ready.
  logic [1:0]           state;
  logic [CFG_WIDTH-1:0] staging;
  logic [CNTW-1:0]      bit_cnt;
  logic                 accept;
  logic                 frame_ok;
  logic                 commit;
  logic [CNTW-1:0]      first_cnt;

  assign accept    = sin_frame & sin_valid;
  assign frame_ok  = (bit_cnt == CNT_FULL);
  assign first_cnt = {{(CNTW-1){1'b0}}, sin_valid};

  always_comb begin
    commit = 1'b0;
    case (state)
      ST_SHIFT:   commit = !sin_frame && frame_ok && !core_busy;
      ST_PENDING: commit = !sin_frame && !core_busy;
      default:    commit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      staging     <= '0;
      bit_cnt     <= '0;
      sout_data   <= 1'b0;
      scaling     <= '0;
      ci_offset   <= '0;
      cr_offset   <= '0;
      max_ctr     <= '1;
      cfg_update  <= 1'b0;
      cfg_pending <= 1'b0;
      cfg_error   <= 1'b0;
      cfg_valid   <= 1'b0;
    end else begin
      cfg_update <= commit;

      if (accept) begin
        staging   <= {staging[CFG_WIDTH-2:0], sin_data};
        sout_data <= staging[CFG_WIDTH-1];
      end

      if (commit) begin
        scaling   <= staging[CFG_WIDTH-1 -: SCALEWIDTH];
        ci_offset <= staging[CI_LSB +: BITWIDTH];
        cr_offset <= staging[CR_LSB +: BITWIDTH];
        max_ctr   <= staging[CTRWIDTH-1:0];
        cfg_valid <= 1'b1;
        cfg_error <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (sin_frame) begin
            state   <= ST_SHIFT;
            bit_cnt <= first_cnt;
          end
        end
        ST_SHIFT: begin
          if (sin_frame) begin
            if (accept && bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
          end else if (frame_ok) begin
            if (core_busy) begin
              state       <= ST_PENDING;
              cfg_pending <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cfg_error <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_PENDING: begin
          // A new frame supersedes the staged one without flagging an error.
          if (sin_frame) begin
            state       <= ST_SHIFT;
            bit_cnt     <= first_cnt;
            cfg_pending <= 1'b0;
          end else if (!core_busy) begin
            state       <= ST_IDLE;
            cfg_pending <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_cfg_loader.sv
// Directed bench for mandel_cfg_loader, with a second loader chained on
// sout_data for the daisy-chain case.
module tb_mandel_cfg_loader;
  import mandel_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic sin_frame, sin_valid, sin_data, core_busy;
  logic sout_data, cfg_update, cfg_pending, cfg_error, cfg_valid;
  logic [1:0]  scaling;
  logic [10:0] ci_offset, cr_offset;
  logic [6:0]  max_ctr;

  logic dn_sout, dn_update, dn_pending, dn_error, dn_valid;
  logic [1:0]  dn_scaling;
  logic [10:0] dn_ci, dn_cr;
  logic [6:0]  dn_max;

  int n_checks = 0;
  int n_pass   = 0;
  int upd_cnt  = 0;

  always #5 clk = ~clk;

  mandel_cfg_loader dut (
    .clk(clk), .reset(reset), .sin_frame(sin_frame), .sin_valid(sin_valid),
    .sin_data(sin_data), .core_busy(core_busy), .sout_data(sout_data),
    .scaling(scaling), .ci_offset(ci_offset), .cr_offset(cr_offset),
    .max_ctr(max_ctr), .cfg_update(cfg_update), .cfg_pending(cfg_pending),
    .cfg_error(cfg_error), .cfg_valid(cfg_valid)
  );

  mandel_cfg_loader u_dn (
    .clk(clk), .reset(reset), .sin_frame(sin_frame), .sin_valid(sin_valid),
    .sin_data(sout_data), .core_busy(core_busy), .sout_data(dn_sout),
    .scaling(dn_scaling), .ci_offset(dn_ci), .cr_offset(dn_cr),
    .max_ctr(dn_max), .cfg_update(dn_update), .cfg_pending(dn_pending),
    .cfg_error(dn_error), .cfg_valid(dn_valid)
  );

  always @(negedge clk) if (cfg_update) upd_cnt++;

  function automatic logic [30:0] mk(input logic [1:0] s, input logic [10:0] ci,
                                     input logic [10:0] cr, input logic [6:0] m);
    return {s, ci, cr, m};
  endfunction

  function automatic logic [30:0] active();
    return {scaling, ci_offset, cr_offset, max_ctr};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n bits MSB first, then drops the frame and clocks the frame-low edge.
  task automatic send_frame(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sin_frame = 1'b1;
      sin_valid = 1'b1;
      sin_data  = bits[i];
      step();
    end
    sin_frame = 1'b0;
    sin_valid = 1'b0;
    sin_data  = 1'b0;
    step();
  endtask

  logic [30:0] wa, wb, wc, wd, we, wf, wg;
  logic [61:0] chain;
  int u0;

  initial begin
    wa = mk(2'd2, 11'h3FF, 11'h401, 7'h55);
    wb = mk(2'd1, 11'h123, 11'h0AB, 7'h3C);
    wc = mk(2'd3, 11'h001, 11'h7FE, 7'h01);
    wd = mk(2'd0, 11'h555, 11'h2AA, 7'h33);
    we = mk(2'd1, 11'h0F0, 11'h70F, 7'h12);
    wf = mk(2'd2, 11'h6B5, 11'h14A, 7'h5A);
    wg = mk(2'd1, 11'h39C, 11'h463, 7'h2D);

    reset = 1'b1; sin_frame = 1'b0; sin_valid = 1'b0; sin_data = 1'b0; core_busy = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_fields", active(), mk(2'd0, 11'h0, 11'h0, 7'h7F));
    check("rst_flags", {sout_data, cfg_update, cfg_pending, cfg_error, cfg_valid}, 5'b0);
    check("rst_state", dut.state, ST_IDLE);

    // Basic commit
    send_frame(wa, 31);
    check("basic_fields", active(), wa);
    check("basic_update", cfg_update, 1'b1);
    check("basic_valid", cfg_valid, 1'b1);
    check("basic_err", cfg_error, 1'b0);
    step();
    check("basic_update_end", cfg_update, 1'b0);
    check("basic_upd_cnt", upd_cnt, 1);

    // Short frame
    u0 = upd_cnt;
    send_frame(wb, 30);
    check("short_err", cfg_error, 1'b1);
    check("short_fields", active(), wa);
    step(); step();
    check("short_no_upd", upd_cnt, u0);

    send_frame(wb, 31);
    check("clr_err", cfg_error, 1'b0);
    check("clr_fields", active(), wb);

    // Long frame
    u0 = upd_cnt;
    step();
    u0 = upd_cnt;
    send_frame({wc, 1'b1}, 32);
    check("long_err", cfg_error, 1'b1);
    check("long_fields", active(), wb);
    step(); step();
    check("long_no_upd", upd_cnt, u0);

    // Busy gating
    core_busy = 1'b1;
    send_frame(wc, 31);
    for (int i = 0; i < 20; i++) begin
      check("busy_hold_fields", active(), wb);
      check("busy_pending", cfg_pending, 1'b1);
      step();
    end
    check("busy_state", dut.state, ST_PENDING);
    core_busy = 1'b0;
    step();
    check("busy_commit", active(), wc);
    check("busy_update", cfg_update, 1'b1);
    check("busy_pend_clr", cfg_pending, 1'b0);
    check("busy_err_clr", cfg_error, 1'b0);

    // New frame while pending
    step();
    u0 = upd_cnt;
    core_busy = 1'b1;
    send_frame(wd, 31);
    check("np_pending1", cfg_pending, 1'b1);
    send_frame(we, 31);
    check("np_pending2", cfg_pending, 1'b1);
    check("np_hold", active(), wc);
    check("np_err", cfg_error, 1'b0);
    core_busy = 1'b0;
    step();
    check("np_commit", active(), we);
    check("np_max", max_ctr, 7'h12);
    step(); step();
    check("np_one_upd", upd_cnt, u0 + 1);

    // Zero-length frame
    sin_frame = 1'b1; sin_valid = 1'b0;
    step();
    sin_frame = 1'b0;
    step();
    check("zero_err", cfg_error, 1'b1);
    check("zero_fields", active(), we);

    // Reset mid-frame
    for (int i = 30; i >= 16; i--) begin
      sin_frame = 1'b1; sin_valid = 1'b1; sin_data = wa[i];
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0; sin_frame = 1'b0; sin_valid = 1'b0; sin_data = 1'b0;
    step();
    check("mid_state", dut.state, ST_IDLE);
    check("mid_err", cfg_error, 1'b0);
    check("mid_fields", active(), mk(2'd0, 11'h0, 11'h0, 7'h7F));
    check("mid_valid", cfg_valid, 1'b0);
    step(); step();

    // Daisy chain: both loaders see 62 valid bits, so both reject the frame;
    // the registered sout adds one bit of delay into the downstream stage.
    chain = {wf, wg};
    u0 = upd_cnt;
    send_frame(chain, 62);
    check("dc_up_err", cfg_error, 1'b1);
    check("dc_dn_err", dn_error, 1'b1);
    check("dc_up_fields", active(), mk(2'd0, 11'h0, 11'h0, 7'h7F));
    check("dc_dn_max", dn_max, 7'h7F);
    check("dc_up_stage", dut.staging, wg);
    check("dc_dn_stage", u_dn.staging, {1'b0, wf[30:1]});
    check("dc_sout", sout_data, wf[0]);
    step();
    check("dc_no_upd", upd_cnt, u0);

    // Chained-length frame on the upstream loader still commits normally.
    send_frame(wg, 31);
    check("dc_up_commit", active(), wg);
    check("dc_dn_commit", {dn_scaling, dn_ci, dn_cr, dn_max}, {wf[0], wg[30:1]});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
